pdm_rec_ctrl: RTL and testbench

//  Sequencer for the PDM microphone record/playback path. Generates the gated microphone clock,

---
 rtl/pdm_rec_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pdm_rec_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_rec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdm_rec_ctrl
// Description : PDM microphone record/playback sequencer (mic clock, sample
//               RAM write/read addressing, PWM load strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_rec_ctrl #(
    parameter int MCLK_DIV   = 40,
    parameter int DEC_RATE   = 128,
    parameter int WAKE_MCLKS = 1024,
    parameter int DEPTH      = 1024,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_rec,
    input  logic          start_play,
    input  logic          dec_valid,
    output logic          m_clk,
    output logic          m_clk_rise,
    output logic          m_lr_sel,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic          amp_load,
    output logic          rec_active,
    output logic          play_active
);

    localparam int DW          = $clog2(MCLK_DIV);
    localparam int PLAY_PERIOD = MCLK_DIV * DEC_RATE;
    localparam int PW          = $clog2(PLAY_PERIOD);
    localparam int WW          = $clog2(WAKE_MCLKS + 1);

    localparam logic [DW-1:0] c_div_last  = DW'(MCLK_DIV - 1);
    localparam logic [DW-1:0] c_div_half  = DW'(MCLK_DIV / 2);
    localparam logic [PW-1:0] c_play_last = PW'(PLAY_PERIOD - 1);
    localparam logic [WW-1:0] c_wake_last = WW'(WAKE_MCLKS - 1);
    localparam logic [AW-1:0] c_addr_last = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAKE   = 2'd1,
        S_RECORD = 2'd2,
        S_PLAY   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_mem_we;
    logic          w_mem_re;

    logic          r_rec_s1, r_rec_s2, r_rec_d, r_rec_edge;
    logic          r_play_s1, r_play_s2, r_play_d, r_play_edge;
    logic [DW-1:0] r_div;
    logic          r_mclk;
    logic          r_mclk_rise;
    logic [WW-1:0] r_wake_cnt;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_rec_len;
    logic [AW:0]   r_nread;
    logic [PW-1:0] r_play_cnt;
    logic          r_amp_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rec_edge) begin
                    w_state_next = S_WAKE;
                end else if (r_play_edge && (r_rec_len != '0)) begin
                    w_state_next = S_PLAY;
                end
            end
            S_WAKE: begin
                if (r_rec_edge) begin
                    w_state_next = S_IDLE;
                end else if (r_mclk_rise && (r_wake_cnt == c_wake_last)) begin
                    w_state_next = S_RECORD;
                end
            end
            S_RECORD: begin
                w_mem_we = dec_valid;
                if (r_rec_edge || (dec_valid && (r_addr == c_addr_last))) begin
                    w_state_next = S_IDLE;
                end
            end
            S_PLAY: begin
                w_mem_re = (r_play_cnt == '0) && (r_nread != r_rec_len);
                if (r_amp_load && (r_nread == r_rec_len)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Button edges are registered so the pulse lands 3 cycles after the level rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_s1    <= 1'b0;
            r_rec_s2    <= 1'b0;
            r_rec_d     <= 1'b0;
            r_rec_edge  <= 1'b0;
            r_play_s1   <= 1'b0;
            r_play_s2   <= 1'b0;
            r_play_d    <= 1'b0;
            r_play_edge <= 1'b0;
        end else begin
            r_rec_s1    <= start_rec;
            r_rec_s2    <= r_rec_s1;
            r_rec_d     <= r_rec_s2;
            r_rec_edge  <= r_rec_s2 & ~r_rec_d;
            r_play_s1   <= start_play;
            r_play_s2   <= r_play_s1;
            r_play_d    <= r_play_s2;
            r_play_edge <= r_play_s2 & ~r_play_d;
        end
    end

    // Mic clock is registered from the next state so it is low in the first IDLE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_mclk      <= 1'b0;
            r_mclk_rise <= 1'b0;
        end else if ((r_state == S_IDLE) && (w_state_next == S_WAKE)) begin
            r_div       <= '0;
            r_mclk      <= 1'b0;
            r_mclk_rise <= 1'b0;
        end else if ((w_state_next == S_WAKE) || (w_state_next == S_RECORD)) begin
            r_mclk      <= (r_div < c_div_half);
            r_mclk_rise <= (r_div == '0);
            r_div       <= (r_div == c_div_last) ? '0 : r_div + DW'(1);
        end else begin
            r_mclk      <= 1'b0;
            r_mclk_rise <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wake_cnt <= '0;
        end else if (r_state != S_WAKE) begin
            r_wake_cnt <= '0;
        end else if (r_mclk_rise) begin
            r_wake_cnt <= r_wake_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_rec_len  <= '0;
            r_nread    <= '0;
            r_play_cnt <= '0;
            r_amp_load <= 1'b0;
        end else begin
            r_amp_load <= w_mem_re;
            if ((r_state == S_WAKE) && (w_state_next == S_RECORD)) begin
                r_addr <= '0;
            end else if ((r_state == S_IDLE) && (w_state_next == S_PLAY)) begin
                r_addr     <= '0;
                r_nread    <= '0;
                r_play_cnt <= '0;
            end else begin
                if (w_mem_we || w_mem_re) begin
                    r_addr <= (r_addr == c_addr_last) ? '0 : r_addr + AW'(1);
                end
                if (w_mem_re) begin
                    r_nread <= r_nread + (AW+1)'(1);
                end
                if (r_state == S_PLAY) begin
                    r_play_cnt <= (r_play_cnt == c_play_last) ? '0 : r_play_cnt + PW'(1);
                end
            end
            // A write in the stopping cycle is part of the recording
            if ((r_state == S_RECORD) && (w_state_next == S_IDLE)) begin
                r_rec_len <= {1'b0, r_addr} + {{AW{1'b0}}, w_mem_we};
            end
        end
    end

    assign m_clk       = r_mclk;
    assign m_clk_rise  = r_mclk_rise;
    assign m_lr_sel    = 1'b0;
    assign mem_we      = w_mem_we;
    assign mem_re      = w_mem_re;
    assign mem_addr    = r_addr;
    assign amp_load    = r_amp_load;
    assign rec_active  = (r_state == S_WAKE) || (r_state == S_RECORD);
    assign play_active = (r_state == S_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_pdm_rec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_rec_ctrl
// Description : Directed self-checking bench for pdm_rec_ctrl (small config).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_rec_ctrl;

    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          start_rec;
    logic          start_play;
    logic          dec_valid;
    logic          m_clk;
    logic          m_clk_rise;
    logic          m_lr_sel;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic          amp_load;
    logic          rec_active;
    logic          play_active;

    int n_tests = 0;
    int n_fail  = 0;

    pdm_rec_ctrl #(
        .MCLK_DIV   (4),
        .DEC_RATE   (4),
        .WAKE_MCLKS (2),
        .DEPTH      (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_rec   (start_rec),
        .start_play  (start_play),
        .dec_valid   (dec_valid),
        .m_clk       (m_clk),
        .m_clk_rise  (m_clk_rise),
        .m_lr_sel    (m_lr_sel),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .amp_load    (amp_load),
        .rec_active  (rec_active),
        .play_active (play_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {23'd0, m_clk, m_clk_rise, m_lr_sel, mem_we, mem_re, amp_load,
                rec_active, play_active, 1'b0} | {29'd0, mem_addr};
    endfunction

    // Single write pulse; entered and left one step after a rising edge
    task automatic write_sample(input int k);
        dec_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("write_%0d", k), {mem_we, mem_addr}, {1'b1, 3'(k)});
        cyc();
        dec_valid = 1'b0;
        cyc();
    endtask

    // Press rec from IDLE and land in the first RECORD cycle
    task automatic go_record();
        start_rec = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("go_rec_active", rec_active, 1'b1);
        start_rec = 1'b0;
        repeat (6) cyc();
    endtask

    task automatic play_check(input int n, input bit poke);
        int bad;
        int bad_addr;
        logic exp_re, exp_ld, exp_pa;
        bad      = 0;
        bad_addr = 0;
        start_play = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("play_latency", play_active, 1'b0);
        cyc();
        start_play = 1'b0;
        for (int c = 0; c <= 16 * (n - 1) + 3; c++) begin
            if (c > 0) cyc();
            if (poke) begin
                start_rec  = (c >= 2) && (c < 6);
                start_play = (c >= 6) && (c < 10);
            end
            @(negedge clk);
            exp_re = ((c % 16) == 0) && ((c / 16) < n);
            exp_ld = ((c % 16) == 1) && ((c / 16) < n);
            exp_pa = (c <= 16 * (n - 1) + 1);
            if ((mem_re !== exp_re) || (amp_load !== exp_ld) || (play_active !== exp_pa) ||
                (mem_we !== 1'b0) || (rec_active !== 1'b0))
                bad++;
            if (exp_re && (mem_addr !== 3'(c / 16)))
                bad_addr++;
        end
        chk($sformatf("play%0d_ctrl_errs", n), bad, 0);
        chk($sformatf("play%0d_addr_errs", n), bad_addr, 0);
        start_rec  = 1'b0;
        start_play = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        logic [31:0] acc;
        logic [4:0]  pat;
        logic [4:0]  rises;
        logic        we_acc;

        rst_n      = 1'b0;
        start_rec  = 1'b0;
        start_play = 1'b0;
        dec_valid  = 1'b0;

        // Reset and idle
        repeat (3) cyc();
        @(negedge clk);
        chk("reset_outs", all_outs(), 0);
        cyc();
        rst_n = 1'b1;
        acc = 0;
        repeat (50) begin
            cyc();
            @(negedge clk);
            acc = acc | all_outs();
        end
        chk("idle_outs", acc, 0);

        // Full recording
        cyc();
        start_rec = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk("rec_edge_latency", rec_active, 1'b0);
        cyc();
        @(negedge clk);
        chk("wake_entry", {rec_active, m_clk}, 2'b10);
        pat    = '0;
        rises  = '0;
        we_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            start_rec = 1'b0;
            dec_valid = (i == 0) || (i == 4);
            @(negedge clk);
            pat    = {pat[3:0], m_clk};
            rises  = {rises[3:0], m_clk_rise};
            we_acc = we_acc | mem_we;
        end
        chk("mclk_pattern", pat, 5'b11001);
        chk("mclk_rises", rises, 5'b10001);
        chk("wake_no_we", we_acc, 1'b0);
        cyc();
        for (int k = 0; k < 8; k++) write_sample(k);
        @(negedge clk);
        chk("full_stop", {rec_active, m_clk, mem_we, m_lr_sel}, 4'b0000);
        repeat (2) cyc();
        play_check(8, 1'b0);

        // Short recording stopped by rec, then played back
        go_record();
        for (int k = 0; k < 3; k++) write_sample(k);
        start_rec = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("early_stop", {rec_active, m_clk}, 2'b00);
        start_rec = 1'b0;
        repeat (3) cyc();
        play_check(3, 1'b0);

        // After reset, play is ignored; simultaneous rec+play goes to WAKE
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        start_play = 1'b1;
        acc = 0;
        repeat (8) begin
            cyc();
            @(negedge clk);
            acc = acc | {30'd0, play_active, mem_re};
        end
        chk("play_empty_ignored", acc, 0);
        start_play = 1'b0;
        repeat (3) cyc();
        start_rec  = 1'b1;
        start_play = 1'b1;
        repeat (4) cyc();
        @(negedge clk);
        chk("rec_wins", {rec_active, play_active}, 2'b10);
        start_rec  = 1'b0;
        start_play = 1'b0;
        repeat (6) cyc();

        // Play ignored during RECORD; coincident write on stop is counted
        write_sample(0);
        write_sample(1);
        start_play = 1'b1;
        acc = 0;
        repeat (6) begin
            cyc();
            @(negedge clk);
            acc = acc | {30'd0, play_active, ~rec_active};
        end
        chk("play_in_record", acc, 0);
        start_play = 1'b0;
        repeat (2) cyc();
        write_sample(2);
        start_rec = 1'b1;
        repeat (3) cyc();
        dec_valid = 1'b1;
        @(negedge clk);
        chk("stop_coincident_write", {mem_we, mem_addr}, {1'b1, 3'd3});
        cyc();
        dec_valid = 1'b0;
        start_rec = 1'b0;
        @(negedge clk);
        chk("stop_after_coincident", rec_active, 1'b0);
        repeat (3) cyc();
        play_check(4, 1'b1);

        // Asynchronous reset mid-recording discards the take
        go_record();
        for (int k = 0; k < 5; k++) write_sample(k);
        dec_valid = 1'b1;
        @(negedge clk);
        chk("pre_reset_write", {mem_we, mem_addr}, {1'b1, 3'd5});
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        dec_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        start_play = 1'b1;
        acc = 0;
        repeat (8) begin
            cyc();
            @(negedge clk);
            acc = acc | {30'd0, play_active, mem_re};
        end
        chk("play_after_reset_ignored", acc, 0);
        start_play = 1'b0;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
